cand_list_gen: RTL and testbench
================================

Name: cand_list_gen

Overview:
Upstream feeder of the random mapping-table selector. Tracks occupancy and age of every slot in a bs-entry buffer and produces the registered candidate bitmask cand_list. Bit i of cand_list is set when slot i is occupied and old enough to be evicted. It also allocates free slots to incoming writers and retires slots when the downstream selector's chosen buffer_index is evicted.

Parameters:
bs, 16, number of buffer slots; must be a power of 2, at least 2.
age_w, 4, width of the per-slot saturating age counter.
age_thresh, 8, minimum age for a slot to become a candidate; must satisfy 1 <= age_thresh <= 2^age_w - 1.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  reset, asynchronous, active-low.
alloc_req  input  1  writer requests a free slot.
alloc_gnt  output  1  registered grant, 1 cycle after the accepted alloc_req.
alloc_index  output  $clog2(bs)  slot granted; valid while alloc_gnt=1.
evict_valid  input  1  retire the slot given by evict_index.
evict_index  input  $clog2(bs)  slot to retire; driven from the selector's buffer_index.
age_tick  input  1  one-cycle strobe; ages all occupied slots.
cand_list  output  bs  registered candidate mask.
occ_count  output  $clog2(bs)+1  number of occupied slots.
full  output  1  occ_count == bs.
empty  output  1  occ_count == 0.
evict_err  output  1  sticky error: an eviction targeted a free slot.

Behaviour:
- State:
  - valid[bs] and age[bs][age_w] registers.
  - All outputs are registered.
- Reset (rst_n=0, asynchronous):
  - valid=0 and all ages=0.
  - cand_list=0, alloc_gnt=0, alloc_index=0, occ_count=0, full=0, empty=1, evict_err=0.
- Allocation:
  - Accepted when alloc_req=1 and the buffer is not full, judged on the valid vector at the start of the cycle.
  - The granted slot is the lowest-index free slot (priority encoder).
  - At the next edge: valid[i]=1, age[i]=0, alloc_gnt=1, alloc_index=i.
  - alloc_req while full: alloc_gnt=0 and alloc_index holds its previous value. There is no queuing; the requester retries.
- Eviction:
  - evict_valid=1 with valid[evict_index]=1: valid cleared and age zeroed at the next edge.
  - evict_valid=1 with valid[evict_index]=0: no state change; evict_err is set and stays set until reset.
- Ageing:
  - On age_tick=1, each occupied slot's age increments, saturating at 2^age_w-1.
  - Free slots stay at 0.
  - A slot allocated in the same cycle starts at age 0; the tick does not apply to it.
- Simultaneous events in one cycle:
  - Alloc and evict are both honoured.
  - The evicted slot is not grantable in that same cycle because it was valid at the start of the cycle.
  - When full, alloc is still refused even if an eviction occurs that cycle. The freed slot is grantable from the next cycle.
  - occ_count next = occ_count + alloc_accepted - evict_accepted.
- Candidate mask:
  - cand_list[i] <= valid_next[i] && (age_next[i] >= age_thresh).
  - The mask reflects post-update state, so an evicted slot drops out of cand_list in the same edge that clears it.
  - Latency from a state change to cand_list is 1 cycle.
- full and empty are computed from occ_count next and registered together with it.
- Downstream contract: cand_list=0 means no eviction is possible this cycle. Consumers must not issue evict_valid for it.

Optional Feature:
Macro CAND_FALLBACK_EN.
- Defined: if full_next=1 and no slot meets age_thresh, cand_list = valid_next (all occupied slots). This keeps the selector from stalling when the buffer is full of young entries.
- Undefined: cand_list is strictly the age-qualified mask. A full buffer with all ages below age_thresh yields cand_list=0.

Test Plan:
- Reset then 3 cycles of alloc_req=1 -> alloc_gnt=1 with alloc_index 0,1,2 on consecutive cycles; occ_count=3, empty=0.
- Fill all 16 slots, then alloc_req=1 -> alloc_gnt=0, full=1; evict_index=5 in the same cycle -> not granted; the next cycle grants alloc_index=5.
- Allocate slot 0, pulse age_tick 8 times -> cand_list=16'h0001 one cycle after the 8th tick; 20 more ticks -> age saturates at 15, cand_list unchanged.
- With slots 0 and 1 both candidates (cand_list=16'h0003), evict_index=1 -> cand_list=16'h0001 and occ_count=1 next cycle; evict_index=1 again -> evict_err=1, sticky.
- Full buffer, all ages 0 -> cand_list=16'hFFFF with CAND_FALLBACK_EN, 16'h0000 without.
- Assert rst_n=0 mid-ageing with 6 slots occupied -> all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cand_list_gen.sv
// cand_list_gen: slot occupancy/age tracker that produces the registered eviction-candidate mask.
// Optional macro CAND_FALLBACK_EN: a full buffer with no aged slot offers every occupied slot.
`default_nettype none

module cand_list_gen #(
    parameter int bs         = 16,
    parameter int age_w      = 4,
    parameter int age_thresh = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   alloc_req,
    output logic                   alloc_gnt,
    output logic [$clog2(bs)-1:0]  alloc_index,
    input  logic                   evict_valid,
    input  logic [$clog2(bs)-1:0]  evict_index,
    input  logic                   age_tick,
    output logic [bs-1:0]          cand_list,
    output logic [$clog2(bs):0]    occ_count,
    output logic                   full,
    output logic                   empty,
    output logic                   evict_err
);

    localparam int                IW      = $clog2(bs);
    localparam int                CW      = IW + 1;
    localparam logic [age_w-1:0]  AGE_MAX = '1;
    localparam logic [age_w-1:0]  THRESH  = age_w'(age_thresh);

    logic [bs-1:0]             valid_q, valid_d;
    logic [bs-1:0][age_w-1:0]  age_q, age_d;
    logic [bs-1:0]             cand_q, cand_d;
    logic                      gnt_q, gnt_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [CW-1:0]             occ_q, occ_d;
    logic                      full_q, full_d;
    logic                      empty_q, empty_d;
    logic                      err_q, err_d;

    logic [IW-1:0]             free_idx;
    logic                      alloc_ok;
    logic                      evict_ok;
    logic [bs-1:0]             qual;

    always_comb begin
        free_idx = '0;
        for (int i = bs - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IW'(i);
        end

        // Both decisions look only at start-of-cycle state, so a slot freed
        // this cycle is never granted in the same cycle.
        alloc_ok = alloc_req && !full_q;
        evict_ok = evict_valid && valid_q[evict_index];

        valid_d = valid_q;
        age_d   = age_q;
        for (int i = 0; i < bs; i++) begin
            if (age_tick && valid_q[i] && (age_q[i] != AGE_MAX)) begin
                age_d[i] = age_q[i] + age_w'(1);
            end
        end
        if (evict_ok) begin
            valid_d[evict_index] = 1'b0;
            age_d[evict_index]   = '0;
        end
        if (alloc_ok) begin
            valid_d[free_idx] = 1'b1;
            age_d[free_idx]   = '0;
        end

        occ_d   = occ_q + CW'(alloc_ok) - CW'(evict_ok);
        full_d  = (occ_d == CW'(bs));
        empty_d = (occ_d == '0);
        gnt_d   = alloc_ok;
        idx_d   = alloc_ok ? free_idx : idx_q;
        err_d   = err_q | (evict_valid & ~valid_q[evict_index]);

        for (int i = 0; i < bs; i++) begin
            qual[i] = valid_d[i] && (age_d[i] >= THRESH);
        end
`ifdef CAND_FALLBACK_EN
        cand_d = (full_d && (qual == '0)) ? valid_d : qual;
`else
        cand_d = qual;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            age_q   <= '0;
            cand_q  <= '0;
            gnt_q   <= 1'b0;
            idx_q   <= '0;
            occ_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            age_q   <= age_d;
            cand_q  <= cand_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            occ_q   <= occ_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            err_q   <= err_d;
        end
    end

    assign cand_list   = cand_q;
    assign alloc_gnt   = gnt_q;
    assign alloc_index = idx_q;
    assign occ_count   = occ_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign evict_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_cand_list_gen.sv
// tb_cand_list_gen: directed stimulus with a reference-model scoreboard for cand_list_gen.
`default_nettype none

module tb_cand_list_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alloc_req;
    logic        alloc_gnt;
    logic [3:0]  alloc_index;
    logic        evict_valid;
    logic [3:0]  evict_index;
    logic        age_tick;
    logic [15:0] cand_list;
    logic [4:0]  occ_count;
    logic        full;
    logic        empty;
    logic        evict_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        gnt;
        logic [3:0]  idx;
        logic [15:0] cand;
        logic [4:0]  occ;
        logic        full;
        logic        empty;
        logic        err;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state
    bit       m_valid[16];
    int       m_age[16];
    int       m_occ;
    bit       m_err;
    bit [3:0] m_idx;

    cand_list_gen #(.bs(16), .age_w(4), .age_thresh(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc_req   (alloc_req),
        .alloc_gnt   (alloc_gnt),
        .alloc_index (alloc_index),
        .evict_valid (evict_valid),
        .evict_index (evict_index),
        .age_tick    (age_tick),
        .cand_list   (cand_list),
        .occ_count   (occ_count),
        .full        (full),
        .empty       (empty),
        .evict_err   (evict_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_age[i]   = 0;
        end
        m_occ = 0;
        m_err = 1'b0;
        m_idx = '0;
        sb_q.delete();
    endtask

    task automatic model_step(input bit req, input bit ev, input int ei, input bit tick);
        exp_t e;
        bit   acc;
        bit   evok;
        int   fi;
        bit   anyq;
        acc  = req && (m_occ < 16);
        fi   = -1;
        for (int i = 15; i >= 0; i--) if (!m_valid[i]) fi = i;
        evok = ev && m_valid[ei];
        if (ev && !m_valid[ei]) m_err = 1'b1;
        if (tick) for (int i = 0; i < 16; i++) if (m_valid[i] && m_age[i] < 15) m_age[i]++;
        if (evok) begin
            m_valid[ei] = 1'b0;
            m_age[ei]   = 0;
            m_occ--;
        end
        if (acc) begin
            m_valid[fi] = 1'b1;
            m_age[fi]   = 0;
            m_occ++;
            m_idx = 4'(fi);
        end
        e.cand = '0;
        anyq   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (m_valid[i] && m_age[i] >= 8) begin
                e.cand[i] = 1'b1;
                anyq      = 1'b1;
            end
        end
`ifdef CAND_FALLBACK_EN
        if (m_occ == 16 && !anyq) for (int i = 0; i < 16; i++) e.cand[i] = m_valid[i];
`endif
        e.gnt   = acc;
        e.idx   = m_idx;
        e.occ   = 5'(m_occ);
        e.full  = (m_occ == 16);
        e.empty = (m_occ == 0);
        e.err   = m_err;
        sb_q.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        chk("alloc_gnt",   32'(alloc_gnt),   32'(e.gnt));
        chk("alloc_index", 32'(alloc_index), 32'(e.idx));
        chk("cand_list",   32'(cand_list),   32'(e.cand));
        chk("occ_count",   32'(occ_count),   32'(e.occ));
        chk("full",        32'(full),        32'(e.full));
        chk("empty",       32'(empty),       32'(e.empty));
        chk("evict_err",   32'(evict_err),   32'(e.err));
    endtask

    task automatic step(input bit req, input bit ev, input int ei, input bit tick);
        @(negedge clk);
        alloc_req   = req;
        evict_valid = ev;
        evict_index = 4'(ei);
        age_tick    = tick;
        model_step(req, ev, ei, tick);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_gnt"},   32'(alloc_gnt),   32'd0);
        chk({tag, "_idx"},   32'(alloc_index), 32'd0);
        chk({tag, "_cand"},  32'(cand_list),   32'd0);
        chk({tag, "_occ"},   32'(occ_count),   32'd0);
        chk({tag, "_full"},  32'(full),        32'd0);
        chk({tag, "_empty"}, 32'(empty),       32'd1);
        chk({tag, "_err"},   32'(evict_err),   32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        alloc_req   = 1'b0;
        evict_valid = 1'b0;
        evict_index = '0;
        age_tick    = 1'b0;
        model_reset();
        #1;
        check_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b1;
        alloc_req   = 1'b0;
        evict_valid = 1'b0;
        evict_index = '0;
        age_tick    = 1'b0;

        // Three allocations land in slots 0,1,2
        do_reset();
        step(1, 0, 0, 0); chk("first_idx0", 32'(alloc_index), 32'd0);
        step(1, 0, 0, 0); chk("first_idx1", 32'(alloc_index), 32'd1);
        step(1, 0, 0, 0); chk("first_idx2", 32'(alloc_index), 32'd2);
        chk("occ3", 32'(occ_count), 32'd3);
        chk("not_empty", 32'(empty), 32'd0);
        step(0, 0, 0, 0); chk("gnt_drops", 32'(alloc_gnt), 32'd0);

        // Fill, then refused alloc with simultaneous evict of slot 5
        for (int i = 3; i < 16; i++) step(1, 0, 0, 0);
        chk("full_set", 32'(full), 32'd1);
`ifdef CAND_FALLBACK_EN
        chk("fallback_all", 32'(cand_list), 32'hFFFF);
`else
        chk("no_fallback", 32'(cand_list), 32'h0000);
`endif
        step(1, 1, 5, 0);
        chk("full_refused", 32'(alloc_gnt), 32'd0);
        chk("idx_held", 32'(alloc_index), 32'd15);
        step(1, 0, 0, 0);
        chk("freed_gnt", 32'(alloc_gnt), 32'd1);
        chk("freed_idx5", 32'(alloc_index), 32'd5);
        step(1, 0, 0, 1);

        // Ageing to threshold and saturation
        do_reset();
        step(1, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 1);
        chk("pre_thresh", 32'(cand_list), 32'h0000);
        step(0, 0, 0, 1);
        chk("at_thresh", 32'(cand_list), 32'h0001);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1);
        chk("saturated", 32'(cand_list), 32'h0001);

        // Two candidates, evict one, then a bad eviction
        step(1, 0, 0, 1);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
        chk("two_cand", 32'(cand_list), 32'h0003);
        step(0, 1, 1, 0);
        chk("evict1_cand", 32'(cand_list), 32'h0001);
        chk("evict1_occ", 32'(occ_count), 32'd1);
        step(0, 1, 1, 0);
        chk("err_set", 32'(evict_err), 32'd1);
        step(0, 0, 0, 0);
        step(1, 0, 0, 1);
        chk("err_sticky", 32'(evict_err), 32'd1);

        // Asynchronous reset in the middle of ageing
        do_reset();
        for (int i = 0; i < 6; i++) step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        @(negedge clk);
        age_tick = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_vals("async");
        age_tick = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0, 0);
        chk("post_rst_idx", 32'(alloc_index), 32'd0);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
